// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store access controller.
// Holds the FSM state encoding, the one-hot access-size codes,
// the misalignment check and the byte-mask helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } lsu_state_e;

  localparam logic [3:0] SIZE_1B = 4'b0001;
  localparam logic [3:0] SIZE_2B = 4'b0010;
  localparam logic [3:0] SIZE_4B = 4'b0100;
  localparam logic [3:0] SIZE_8B = 4'b1000;

  // An access is misaligned if it crosses its natural boundary.
  // Any size code that is not one-hot is also rejected here.
  function automatic logic is_misaligned(input logic [3:0] size,
                                         input logic [2:0] offset);
    logic mis;
    case (size)
      SIZE_1B: mis = 1'b0;
      SIZE_2B: mis = offset[0];
      SIZE_4B: mis = |offset[1:0];
      SIZE_8B: mis = |offset;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  // Unshifted byte mask for a given access size; illegal sizes give 0.
  function automatic logic [7:0] size_mask(input logic [3:0] size);
    logic [7:0] mask;
    case (size)
      SIZE_1B: mask = 8'h01;
      SIZE_2B: mask = 8'h03;
      SIZE_4B: mask = 8'h0F;
      SIZE_8B: mask = 8'hFF;
      default: mask = 8'h00;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lsu_access_ctrl_if.sv
// Bundle of the EX request/response, byte-shifter and BIU signals of
// the access controller. The slave modport is the controller's view,
// the master modport is the view of the surrounding pipeline/bus.
interface lsu_access_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic        req_unsign;
  logic [3:0]  req_size;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;

  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_misalign;
  logic        resp_fault;

  logic        shf_unsign;
  logic [2:0]  shf_addr;
  logic [3:0]  shf_size;
  logic [63:0] shf_data_in;
  logic [63:0] shf_data_write;
  logic [63:0] shf_data_lsu_cache;

  logic        biu_req;
  logic        biu_we;
  logic [63:0] biu_addr;
  logic [7:0]  biu_bsel;
  logic [63:0] biu_wdata;
  logic        biu_ack;
  logic        biu_err;

  modport slave (
    input  req_valid, req_store, req_unsign, req_size, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_misalign, resp_fault,
    output shf_unsign, shf_addr, shf_size, shf_data_in,
    input  shf_data_write, shf_data_lsu_cache,
    output biu_req, biu_we, biu_addr, biu_bsel, biu_wdata,
    input  biu_ack, biu_err
  );

  modport master (
    output req_valid, req_store, req_unsign, req_size, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_misalign, resp_fault,
    input  shf_unsign, shf_addr, shf_size, shf_data_in,
    output shf_data_write, shf_data_lsu_cache,
    input  biu_req, biu_we, biu_addr, biu_bsel, biu_wdata,
    output biu_ack, biu_err
  );

endinterface

// File: rtl/lsu_bsel_gen.sv
// Byte-lane select generator: places the size mask on the lanes
// addressed by the low three address bits of a 64-bit bus word.
module lsu_bsel_gen
  import lsu_pkg::*;
(
  input  logic [3:0] size,
  input  logic [2:0] offset,
  output logic [7:0] bsel
);

  assign bsel = size_mask(size) << offset;

endmodule

// File: rtl/lsu_access_ctrl.sv
// Load/store access controller between the EX stage and the BIU.
// Accepts one request at a time, rejects misaligned accesses without
// touching the bus, otherwise issues one bus word access and returns
// a single-cycle response.
// Optional feature: define LSU_TIMEOUT_EN to fault an access whose
// biu_ack does not arrive within TIMEOUT_CYC cycles of ISSUE.
module lsu_access_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256
)
(
  input logic          clk,
  input logic          rst_n,
  lsu_access_ctrl_if.slave bus
);

  // A timeout window shorter than two cycles cannot be counted sensibly.
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("lsu_access_ctrl: TIMEOUT_CYC must be at least 2");
  end

  lsu_state_e  state;
  logic        req_ready_q;
  logic        store_q;
  logic        unsign_q;
  logic [3:0]  size_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic        biu_req_q;
  logic        resp_valid_q;
  logic [63:0] resp_rdata_q;
  logic        resp_misalign_q;
  logic        resp_fault_q;

  logic        accept;
  logic        req_mis;
  logic        timeout_hit;
  logic [7:0]  bsel;

  assign accept  = bus.req_valid && req_ready_q;
  assign req_mis = is_misaligned(bus.req_size, bus.req_addr[2:0]);

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] issue_cnt;

  assign timeout_hit = (issue_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Counts ISSUE cycles of the current access; restarts on every accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
    end else if (accept) begin
      issue_cnt <= '0;
    end else if (state == ISSUE && !bus.biu_ack && !timeout_hit) begin
      issue_cnt <= issue_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Access FSM: latches the request, drives the bus request and
  // produces the one-cycle response, all as registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      req_ready_q     <= 1'b0;
      store_q         <= 1'b0;
      unsign_q        <= 1'b0;
      size_q          <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      biu_req_q       <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_misalign_q <= 1'b0;
      resp_fault_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            store_q     <= bus.req_store;
            unsign_q    <= bus.req_unsign;
            size_q      <= bus.req_size;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            if (req_mis) begin
              state           <= RESP;
              resp_valid_q    <= 1'b1;
              resp_misalign_q <= 1'b1;
              resp_fault_q    <= 1'b0;
              resp_rdata_q    <= '0;
            end else begin
              state     <= ISSUE;
              biu_req_q <= 1'b1;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end

        ISSUE: begin
          if (bus.biu_ack) begin
            state           <= RESP;
            biu_req_q       <= 1'b0;
            resp_valid_q    <= 1'b1;
            resp_misalign_q <= 1'b0;
            resp_fault_q    <= bus.biu_err;
            resp_rdata_q    <= store_q ? 64'd0 : bus.shf_data_lsu_cache;
          end else if (timeout_hit) begin
            state           <= RESP;
            biu_req_q       <= 1'b0;
            resp_valid_q    <= 1'b1;
            resp_misalign_q <= 1'b0;
            resp_fault_q    <= 1'b1;
            resp_rdata_q    <= '0;
          end
        end

        RESP: begin
          state           <= IDLE;
          req_ready_q     <= 1'b1;
          resp_valid_q    <= 1'b0;
          resp_misalign_q <= 1'b0;
          resp_fault_q    <= 1'b0;
          resp_rdata_q    <= '0;
        end

        default: begin
          state       <= IDLE;
          req_ready_q <= 1'b0;
          biu_req_q   <= 1'b0;
        end
      endcase
    end
  end

  lsu_bsel_gen u_bsel_gen (
    .size   (size_q),
    .offset (addr_q[2:0]),
    .bsel   (bsel)
  );

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.resp_misalign = resp_misalign_q;
  assign bus.resp_fault    = resp_fault_q;

  assign bus.shf_unsign    = unsign_q;
  assign bus.shf_addr      = addr_q[2:0];
  assign bus.shf_size      = size_q;
  assign bus.shf_data_in   = wdata_q;

  assign bus.biu_req       = biu_req_q;
  assign bus.biu_we        = (state == ISSUE) && store_q;
  assign bus.biu_addr      = (state == ISSUE) ? {addr_q[63:3], 3'b000} : 64'd0;
  assign bus.biu_bsel      = (state == ISSUE) ? bsel : 8'h00;
  assign bus.biu_wdata     = (state == ISSUE) ? bus.shf_data_write : 64'd0;

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Directed, scoreboard-based bench for lsu_access_ctrl.
// Expected responses are queued when a request is driven and popped
// when resp_valid appears. Build with LSU_TIMEOUT_EN to add the
// bus-timeout scenario (TIMEOUT_CYC = 8).
module tb_lsu_access_ctrl;

`ifdef LSU_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  typedef struct {
    logic [63:0] rdata;
    logic        misalign;
    logic        fault;
  } resp_t;

  logic  clk;
  logic  rst_n;
  int    checks;
  int    errors;
  resp_t exp_q[$];

  lsu_access_ctrl_if bus();

  lsu_access_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExpected(input logic [63:0] rdata, input logic misalign,
                              input logic fault);
    resp_t e;
    e.rdata    = rdata;
    e.misalign = misalign;
    e.fault    = fault;
    exp_q.push_back(e);
  endtask

  // Presents a request from a negedge and returns #1 after the accepting edge.
  task automatic applyStimulus(input logic store, input logic unsign,
                               input logic [3:0] size, input logic [63:0] addr,
                               input logic [63:0] wdata);
    int n;
    @(negedge clk);
    bus.req_store  = store;
    bus.req_unsign = unsign;
    bus.req_size   = size;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Raises biu_ack (with err) after 'delay' further clock edges for one cycle.
  task automatic doAck(input logic err, input int delay);
    repeat (delay) @(posedge clk);
    #1;
    bus.biu_ack = 1'b1;
    bus.biu_err = err;
    @(posedge clk);
    #1;
    bus.biu_ack = 1'b0;
    bus.biu_err = 1'b0;
  endtask

  // Waits (bounded) for resp_valid, checks latency and contents against the
  // scoreboard head, then checks the response lasts exactly one cycle.
  task automatic waitResp(input string tag, input int exp_lat);
    int    lat;
    resp_t e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.resp_valid !== 1'b1 && lat < 40);
    checkOutput({tag, "_latency"}, lat, exp_lat);
    if (bus.resp_valid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({tag, "_rdata"}, bus.resp_rdata, e.rdata);
      checkOutput({tag, "_misalign"}, bus.resp_misalign, e.misalign);
      checkOutput({tag, "_fault"}, bus.resp_fault, e.fault);
      checkOutput({tag, "_ready_in_resp"}, bus.req_ready, 1'b0);
      @(negedge clk);
      checkOutput({tag, "_valid_one_cycle"}, bus.resp_valid, 1'b0);
      checkOutput({tag, "_fault_cleared"}, bus.resp_fault, 1'b0);
      checkOutput({tag, "_ready_after"}, bus.req_ready, 1'b1);
    end else begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_response: observed resp_valid=%b queue=%0d expected a response",
             tag, bus.resp_valid, exp_q.size());
    end
  endtask

  // Directed test sequence.
  initial begin
    int seen;
    logic [63:0] cache_val;
    logic [63:0] wr_val;

    checks = 0;
    errors = 0;
    cache_val = 64'h1122_3344_5566_7788;
    wr_val    = 64'h0000_AB00_0000_0000;

    rst_n                  = 1'b0;
    bus.req_valid          = 1'b0;
    bus.req_store          = 1'b0;
    bus.req_unsign         = 1'b0;
    bus.req_size           = 4'b0000;
    bus.req_addr           = 64'd0;
    bus.req_wdata          = 64'd0;
    bus.shf_data_write     = wr_val;
    bus.shf_data_lsu_cache = cache_val;
    bus.biu_ack            = 1'b0;
    bus.biu_err            = 1'b0;

    // Reset state
    #1;
    checkOutput("rst_ready", bus.req_ready, 1'b0);
    checkOutput("rst_biu_req", bus.biu_req, 1'b0);
    checkOutput("rst_resp_valid", bus.resp_valid, 1'b0);
    checkOutput("rst_shf_size", bus.shf_size, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_before_first_clk", bus.req_ready, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("ready_after_first_clk", bus.req_ready, 1'b1);

    // Aligned 8B load, ack three cycles after accept
    pushExpected(cache_val, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b1000, 64'h1000, 64'd0);
    @(negedge clk);
    checkOutput("ld8_biu_req", bus.biu_req, 1'b1);
    checkOutput("ld8_bsel", bus.biu_bsel, 8'hFF);
    checkOutput("ld8_addr", bus.biu_addr, 64'h1000);
    checkOutput("ld8_we", bus.biu_we, 1'b0);
    checkOutput("ld8_ready_busy", bus.req_ready, 1'b0);
    doAck(1'b0, 2);
    checkOutput("ld8_req_dropped", bus.biu_req, 1'b0);
    waitResp("ld8", 1);

    // 1B store of 0xAB at 0x1005
    pushExpected(64'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0001, 64'h1005, 64'hAB);
    @(negedge clk);
    checkOutput("st1_addr", bus.biu_addr, 64'h1000);
    checkOutput("st1_bsel", bus.biu_bsel, 8'h20);
    checkOutput("st1_we", bus.biu_we, 1'b1);
    checkOutput("st1_wdata", bus.biu_wdata, wr_val);
    checkOutput("st1_shf_in", bus.shf_data_in, 64'hAB);
    checkOutput("st1_shf_addr", bus.shf_addr, 3'd5);
    checkOutput("st1_shf_size", bus.shf_size, 4'b0001);
    doAck(1'b0, 0);
    waitResp("st1", 1);

    // Misaligned 4B load at 0x1002: no bus access, response next cycle
    pushExpected(64'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0100, 64'h1002, 64'd0);
    checkOutput("mis4_no_biu_req", bus.biu_req, 1'b0);
    waitResp("mis4", 1);

    // Non-one-hot size is rejected as misaligned
    pushExpected(64'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0011, 64'h1000, 64'd0);
    checkOutput("badsize_no_biu_req", bus.biu_req, 1'b0);
    waitResp("badsize", 1);

    // 2B unsigned load at 0x2006 with ack+err
    cache_val = 64'hDEAD_0000_0000_0000;
    bus.shf_data_lsu_cache = cache_val;
    pushExpected(cache_val, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'b0010, 64'h2006, 64'd0);
    @(negedge clk);
    checkOutput("ld2_bsel", bus.biu_bsel, 8'hC0);
    checkOutput("ld2_addr", bus.biu_addr, 64'h2000);
    checkOutput("ld2_unsign", bus.shf_unsign, 1'b1);
    doAck(1'b1, 0);
    waitResp("ld2err", 1);

    // Minimum latency: ack in the first ISSUE cycle
    pushExpected(cache_val, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0100, 64'h2004, 64'd0);
    bus.biu_ack = 1'b1;
    @(negedge clk);
    checkOutput("minlat_biu_req", bus.biu_req, 1'b1);
    checkOutput("minlat_bsel", bus.biu_bsel, 8'hF0);
    @(posedge clk);
    #1;
    bus.biu_ack = 1'b0;
    waitResp("minlat", 1);

    // Ack while idle is ignored
    @(negedge clk);
    bus.biu_ack = 1'b1;
    bus.biu_err = 1'b1;
    @(posedge clk);
    #1;
    bus.biu_ack = 1'b0;
    bus.biu_err = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1 || bus.biu_req === 1'b1) seen++;
    end
    checkOutput("idle_ack_ignored", seen, 0);

    // Reset during ISSUE abandons the access
    applyStimulus(1'b0, 1'b0, 4'b1000, 64'h3000, 64'd0);
    @(negedge clk);
    checkOutput("rstiss_biu_req_before", bus.biu_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstiss_biu_req_now", bus.biu_req, 1'b0);
    checkOutput("rstiss_bsel_now", bus.biu_bsel, 8'h00);
    checkOutput("rstiss_ready_now", bus.req_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstiss_ready_after", bus.req_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) seen++;
    end
    checkOutput("rstiss_no_resp", seen, 0);

`ifdef LSU_TIMEOUT_EN
    // No ack: fault after TO ISSUE cycles, late ack ignored
    pushExpected(64'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'b1000, 64'h4000, 64'd0);
    waitResp("timeout", TO + 1);
    checkOutput("timeout_req_dropped", bus.biu_req, 1'b0);
    bus.biu_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.biu_ack = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) seen++;
    end
    checkOutput("timeout_late_ack_ignored", seen, 0);
`endif

    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_access_ctrl.md
LSU_ACCESS_CTRL -- requirements
Module: lsu_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 256, meaning the number of cycles to wait for biu_ack before a fault (used only with LSU_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have EX request ports:
- req_valid, input, 1.
- req_ready, output, 1.
- req_store, input, 1.
- req_unsign, input, 1.
- req_size, input, 4, one-hot: 0001=1B, 0010=2B, 0100=4B, 1000=8B.
- req_addr, input, 64.
- req_wdata, input, 64.
REQ-005 SHALL have EX response ports:
- resp_valid, output, 1.
- resp_rdata, output, 64.
- resp_misalign, output, 1.
- resp_fault, output, 1.
REQ-006 SHALL have byte-shifter ports:
- shf_unsign, output, 1.
- shf_addr, output, 3.
- shf_size, output, 4.
- shf_data_in, output, 64.
- shf_data_write, input, 64.
- shf_data_lsu_cache, input, 64.
REQ-007 SHALL have BIU ports:
- biu_req, output, 1.
- biu_we, output, 1.
- biu_addr, output, 64, 8-byte aligned.
- biu_bsel, output, 8.
- biu_wdata, output, 64.
- biu_ack, input, 1.
- biu_err, input, 1.

Function
REQ-008 SHALL implement the FSM states IDLE, ISSUE and RESP.
REQ-009 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1.
REQ-010 On accept, SHALL register store, unsign, size, addr and wdata; the shf_* outputs SHALL be driven only from these registers and stay stable until return to IDLE.
REQ-011 Misalignment SHALL be detected as: size 2B with addr[0]=1; size 4B with addr[1:0]!=0; size 8B with addr[2:0]!=0; size not one-hot.
REQ-012 An accepted misaligned request SHALL go IDLE->RESP with no BIU access and resp_misalign=1.
REQ-013 An accepted aligned request SHALL go IDLE->ISSUE, with biu_req=1 from the next cycle until biu_ack.
REQ-014 In ISSUE, biu_addr SHALL be {addr[63:3],3'b0} and biu_we SHALL equal store.
REQ-015 In ISSUE, biu_wdata SHALL equal shf_data_write and biu_bsel SHALL be the size mask shifted left by addr[2:0].
REQ-016 biu_ack in ISSUE SHALL move the FSM to RESP and capture shf_data_lsu_cache into resp_rdata (0 for stores).
REQ-017 biu_ack together with biu_err SHALL set resp_fault=1; data is still captured.
REQ-018 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE; resp_* SHALL be 0 outside RESP.
REQ-019 Minimum aligned latency SHALL be: accept at cycle 0, biu_req at cycle 1, ack at cycle 1, resp_valid at cycle 2.
REQ-020 biu_ack outside ISSUE SHALL be ignored.
REQ-021 A new request SHALL NOT be accepted in the RESP cycle.

Reset
REQ-022 rst_n low SHALL force IDLE immediately and set all outputs to 0, except req_ready=1 after the first clock.
REQ-023 A reset during ISSUE SHALL abandon the access with no response and drop biu_req immediately.

Configuration
REQ-024 With LSU_TIMEOUT_EN defined, a counter SHALL clear on entry to ISSUE and increment each ISSUE cycle.
REQ-025 With LSU_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYC-1 without biu_ack, the FSM SHALL go to RESP with resp_fault=1, resp_rdata=0 and biu_req dropped.
REQ-026 Without LSU_TIMEOUT_EN, the counter logic SHALL be absent and ISSUE SHALL wait indefinitely.

Structure
REQ-027 A shared package lsu_pkg SHALL hold the FSM state enum, the one-hot size constants and the misalign-check function.
REQ-028 Byte-select generation SHALL be one sub-module, lsu_bsel_gen (size, addr[2:0] -> bsel[7:0]).

Verification
REQ-029 Aligned 8B load at addr 0x1000, ack after 3 cycles -> biu_bsel=0xFF; resp_valid 1 cycle after ack; resp_rdata = shifter value.
REQ-030 1B store of wdata 0xAB at addr 0x1005 -> biu_addr=0x1000, biu_bsel=0x20, biu_we=1, biu_wdata=shf_data_write.
REQ-031 4B load at addr 0x1002 -> no biu_req; resp_valid at cycle 1 with resp_misalign=1.
REQ-032 2B load at addr 0x2006 with ack and err both 1 -> resp_fault=1, resp_misalign=0.
REQ-033 rst_n low during ISSUE -> biu_req=0 at once; no resp_valid; req_ready=1 after release.
REQ-034 LSU_TIMEOUT_EN with TIMEOUT_CYC=8 and no ack -> resp_fault=1 at ISSUE cycle 8; a late ack is then ignored.
